// File: rtl/vx_commit_arb.sv
// Commit merger for one issue slot: round-robin arbiter with multi-packet lock feeding a 2-entry FIFO.
// Optional `VX_COMMIT_ARB_PERF_EN adds stall and conflict counters.
module vx_commit_arb #(
  parameter int NUM_UNITS = 5,
  parameter int DATAW     = 128,
  parameter int CNT_W     = 48
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_UNITS-1:0]       in_valid,
  input  logic [NUM_UNITS*DATAW-1:0] in_data,
  input  logic [NUM_UNITS-1:0]       in_eop,
  output logic [NUM_UNITS-1:0]       in_ready,
  output logic                       out_valid,
  output logic [DATAW-1:0]           out_data,
  output logic                       out_eop,
  output logic [2:0]                 out_unit,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           retired_count
`ifdef VX_COMMIT_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]           perf_stall_cycles,
  output logic [CNT_W-1:0]           perf_conflict_cycles
`endif
);

  // state    | meaning
  // UNLOCKED | round-robin among valid units
  // LOCKED   | grant held by lock_unit_q until its eop packet is accepted
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

  localparam logic [3:0] NU4  = 4'(NUM_UNITS);
  localparam logic [2:0] LAST = 3'(NUM_UNITS - 1);

  lock_e      state_q;
  logic [2:0] lock_unit_q;
  logic [2:0] rr_q;

  logic [7:0] vld8, eop8;
  assign vld8 = 8'(in_valid);
  assign eop8 = 8'(in_eop);

  logic [2:0]       gnt_idx;
  logic             gnt_vld;
  logic [3:0]       cand;
  logic [DATAW-1:0] gnt_data;
  logic             gnt_eop;

  // Walk offsets from high to low so the smallest offset from rr_q wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    if (state_q == LOCKED) begin
      gnt_idx = lock_unit_q;
      gnt_vld = vld8[lock_unit_q];
    end else begin
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
        cand = {1'b0, rr_q} + 4'(k);
        if (cand >= NU4) cand = cand - NU4;
        if (vld8[cand[2:0]]) begin
          gnt_idx = cand[2:0];
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (gnt_idx == 3'(i)) gnt_data = in_data[i*DATAW +: DATAW];
    end
  end
  assign gnt_eop = eop8[gnt_idx];

  logic [DATAW-1:0] buf_data_q [2];
  logic [1:0]       buf_eop_q;
  logic [2:0]       buf_unit_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             full, push, pop;

  assign full = (cnt_q == 2'd2);
  assign push = gnt_vld & ~full & ~reset;
  assign pop  = out_valid & out_ready;

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      in_ready[i] = push && (gnt_idx == 3'(i));
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = buf_data_q[rd_q];
  assign out_eop   = buf_eop_q[rd_q];
  assign out_unit  = buf_unit_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_unit_q[i] <= '0;
      end
      buf_eop_q <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_q] <= gnt_data;
        buf_eop_q[wr_q]  <= gnt_eop;
        buf_unit_q[wr_q] <= gnt_idx;
        wr_q             <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      lock_unit_q <= '0;
      rr_q        <= '0;
    end else if (push) begin
      case (state_q)
        UNLOCKED: if (!gnt_eop) begin
          state_q     <= LOCKED;
          lock_unit_q <= gnt_idx;
        end
        LOCKED: if (gnt_eop) state_q <= UNLOCKED;
        default: state_q <= UNLOCKED;
      endcase
      if (gnt_eop) rr_q <= (gnt_idx == LAST) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

  logic [CNT_W-1:0] retired_q, retired_d;
  assign retired_d     = retired_q + CNT_W'(1);
  assign retired_count = retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               retired_q <= '0;
    else if (pop && out_eop) retired_q <= retired_d;
  end

`ifdef VX_COMMIT_ARB_PERF_EN
  logic [CNT_W-1:0] stall_q, conflict_q;
  logic             multi_vld;
  assign multi_vld            = ($countones(in_valid) > 1);
  assign perf_stall_cycles    = stall_q;
  assign perf_conflict_cycles = conflict_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q    <= '0;
      conflict_q <= '0;
    end else begin
      if (out_valid && !out_ready) stall_q    <= stall_q + CNT_W'(1);
      if (multi_vld && push)       conflict_q <= conflict_q + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Scoreboard bench for vx_commit_arb: a spec-level arbitration model predicts in_ready and queues
// expected packets; a separate monitor pops and compares on every output fire.
module tb_vx_commit_arb;
  localparam int N  = 5;
  localparam int DW = 128;
  localparam int CW = 48;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid, in_eop, in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_eop, out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_unit;
  logic [CW-1:0]   retired_count;
`ifdef VX_COMMIT_ARB_PERF_EN
  logic [CW-1:0]   perf_stall_cycles, perf_conflict_cycles;
`endif

  vx_commit_arb #(.NUM_UNITS(N), .DATAW(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_eop(in_eop), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_eop(out_eop), .out_unit(out_unit),
    .out_ready(out_ready), .retired_count(retired_count)
`ifdef VX_COMMIT_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
    logic [2:0]    u;
  } pkt_t;

  pkt_t sb[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  int            rr_m = 0;
  int            lku_m = 0;
  bit            lk_m = 1'b0;
  logic [CW-1:0] ret_m = '0;
  logic [CW-1:0] stall_m = '0;
  logic [CW-1:0] conf_m = '0;
  int            pre_size = 0;
  int            last_g = -1;
  bit            last_fire = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Grant rule: lowest valid index at or above rr, else lowest valid overall; locked holds lock unit.
  function automatic int mgrant(input logic [N-1:0] v);
    if (lk_m) return v[lku_m] ? lku_m : -1;
    for (int i = rr_m; i < N; i++) if (v[i]) return i;
    for (int i = 0; i < rr_m; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] e, input logic rdy);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_eop    = e;
    out_ready = rdy;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    #1;
    last_fire = 1'b0;
    last_g    = -1;
    if (!reset) begin
      g        = mgrant(v);
      pre_size = sb.size();
      exp_rdy  = (g >= 0 && pre_size < 2) ? N'(1 << g) : '0;
      chk("in_ready", DW'(in_ready), DW'(exp_rdy));
`ifdef VX_COMMIT_ARB_PERF_EN
      chk("perf_stall", DW'(perf_stall_cycles), DW'(stall_m));
      chk("perf_conflict", DW'(perf_conflict_cycles), DW'(conf_m));
`endif
      if (pre_size > 0 && !rdy) stall_m++;
      if (exp_rdy != '0) begin
        pkt_t p;
        last_fire = 1'b1;
        last_g    = g;
        if ($countones(v) > 1) conf_m++;
        p.d = in_data[g*DW +: DW];
        p.e = e[g];
        p.u = 3'(g);
        sb.push_back(p);
        if (!lk_m && !e[g]) begin
          lk_m  = 1'b1;
          lku_m = g;
        end else if (lk_m && e[g]) begin
          lk_m = 1'b0;
        end
        if (e[g]) rr_m = (g + 1) % N;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = '1;
    in_eop   = '1;
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_retired", DW'(retired_count), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    sb.delete();
    rr_m = 0; lk_m = 1'b0; lku_m = 0;
    ret_m = '0; stall_m = '0; conf_m = '0; pre_size = 0;
    @(negedge clk);
    in_valid = '0;
    reset    = 1'b0;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an accepted output
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_e;
  logic [DW-1:0] prev_d;
  logic [2:0]    prev_u;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        chk("out_valid", DW'(out_valid), DW'(pre_size > 0));
        chk("retired_count", DW'(retired_count), DW'(ret_m));
        if (prev_v && !prev_r && out_valid) begin
          chk("hold_data", out_data, prev_d);
          chk("hold_eop", DW'(out_eop), DW'(prev_e));
          chk("hold_unit", DW'(out_unit), DW'(prev_u));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", DW'(out_valid), '0);
          end else begin
            pkt_t p;
            p = sb.pop_front();
            chk("out_data", out_data, p.d);
            chk("out_eop", DW'(out_eop), DW'(p.e));
            chk("out_unit", DW'(out_unit), DW'(p.u));
            if (p.e) ret_m++;
          end
        end
        prev_v = out_valid; prev_r = out_ready;
        prev_d = out_data;  prev_e = out_eop; prev_u = out_unit;
      end
    end
  end

  initial begin
    int lsu_n;
    reset = 1'b1; in_valid = '0; in_eop = '0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_eop", DW'(out_eop), '0);
    chk("rst_out_unit", DW'(out_unit), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    chk("rst_retired", DW'(retired_count), '0);
    @(negedge clk);
    reset = 1'b0;

    // single unit back-to-back
    repeat (3) cyc(5'b00001, 5'b11111, 1'b1);
    repeat (3) cyc(5'b00000, 5'b11111, 1'b1);
    chk("single_retired", DW'(retired_count), DW'(3));

    // round robin from a fresh pointer
    do_reset();
    repeat (6) cyc(5'b11111, 5'b11111, 1'b1);
    repeat (3) cyc(5'b00000, 5'b11111, 1'b1);
    chk("rr_retired", DW'(retired_count), DW'(6));

    // LSU multi-packet lock with ALU and SFU competing
    lsu_n = 0;
    for (int c = 0; c < 20 && lsu_n < 3; c++) begin
      cyc(5'b10011, {3'b111, (lsu_n == 2), 1'b1}, 1'b1);
      if (last_fire && last_g == 1) lsu_n++;
    end
    chk("lock_lsu_packets", DW'(lsu_n), DW'(3));
    repeat (4) cyc(5'b10011, 5'b11111, 1'b1);

    // backpressure then drain
    repeat (4) cyc(5'b11111, 5'b11111, 1'b0);
    repeat (4) cyc(5'b00000, 5'b11111, 1'b1);

    // randomized traffic
    for (int c = 0; c < 400; c++)
      cyc(N'($urandom), N'($urandom | $urandom), ($urandom_range(0, 3) != 0));

    // reset while LSU holds the lock
    for (int c = 0; c < 10 && lk_m; c++) cyc(5'b11111, 5'b11111, 1'b1);
    for (int c = 0; c < 10 && !(lk_m && lku_m == 1); c++) cyc(5'b00010, 5'b00000, 1'b1);
    chk("lock_before_reset", DW'(lk_m && lku_m == 1), DW'(1));
    do_reset();
    repeat (3) cyc(5'b11111, 5'b11111, 1'b1);

    // stall and conflict counters
    repeat (3) cyc(5'b00000, 5'b11111, 1'b1);
    cyc(5'b00001, 5'b11111, 1'b0);
    repeat (7) cyc(5'b00000, 5'b11111, 1'b0);
    repeat (3) cyc(5'b00011, 5'b11111, 1'b1);
    repeat (4) cyc(5'b00000, 5'b11111, 1'b1);
`ifdef VX_COMMIT_ARB_PERF_EN
    chk("perf_stall_total", DW'(perf_stall_cycles), DW'(stall_m));
    chk("perf_conflict_total", DW'(perf_conflict_cycles), DW'(conf_m));
`endif
    chk("scoreboard_empty", DW'(sb.size()), '0);

    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
